// File: rtl/deco_bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) with
// valid/ready handshakes. Optional two's-complement input via DECO_SIGNED_EN.
module deco_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  overflow
`ifdef DECO_SIGNED_EN
  ,
  output logic                  out_sign
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int BW = 4 * DIGITS;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [BW-1:0]     bcd_q, bcd_d, bcd_adj;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  load_val;
  logic              sign_q, sign_d;

`ifdef DECO_SIGNED_EN
  // Negating the most negative value wraps back to itself, which read as
  // unsigned is exactly its magnitude 2^(WIDTH-1).
  assign load_val = in_data[WIDTH-1] ? (~in_data + WIDTH'(1)) : in_data;
  assign sign_d   = (state_q == IDLE && in_valid) ? in_data[WIDTH-1] : sign_q;
  assign out_sign = sign_q;
`else
  assign load_val = in_data;
  assign sign_d   = 1'b0;
`endif

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    bcd_adj     = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_d      = load_val;
          bcd_d      = '0;
          ovf_d      = 1'b0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = CONV;
        end
      end
      CONV: begin
        // A carry out of the top digit means the value needs more digits.
        bcd_d = {bcd_adj[BW-2:0], bin_q[WIDTH-1]};
        bin_d = {bin_q[WIDTH-2:0], 1'b0};
        ovf_d = ovf_q | bcd_adj[BW-1];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sign_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      sign_q      <= sign_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_bcd   = bcd_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_deco_bcd_seq.sv
// Bench for deco_bcd_seq: three instances (8/3, 4/2, 8/2) checked against a
// decimal-arithmetic reference model; signed tests run when DECO_SIGNED_EN is set.
module tb_deco_bcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid [3];
  logic [7:0] in_data  [3];
  logic       out_ready[3];
  logic       in_ready [3];
  logic       out_valid[3];
  logic       ovf      [3];
  logic       sgn      [3];
  logic [11:0] bcd0;
  logic [7:0]  bcd1, bcd2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_accept = 0;

  deco_bcd_seq #(.WIDTH(8), .DIGITS(3)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_bcd(bcd0), .overflow(ovf[0])
`ifdef DECO_SIGNED_EN
    , .out_sign(sgn[0])
`endif
  );
  deco_bcd_seq #(.WIDTH(4), .DIGITS(2)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1][3:0]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_bcd(bcd1), .overflow(ovf[1])
`ifdef DECO_SIGNED_EN
    , .out_sign(sgn[1])
`endif
  );
  deco_bcd_seq #(.WIDTH(8), .DIGITS(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_bcd(bcd2), .overflow(ovf[2])
`ifdef DECO_SIGNED_EN
    , .out_sign(sgn[2])
`endif
  );

`ifndef DECO_SIGNED_EN
  assign sgn[0] = 1'b0;
  assign sgn[1] = 1'b0;
  assign sgn[2] = 1'b0;
`endif

  function automatic int w_of(input int i);
    return (i == 1) ? 4 : 8;
  endfunction

  function automatic int d_of(input int i);
    return (i == 0) ? 3 : 2;
  endfunction

  function automatic logic [11:0] get_bcd(input int i);
    case (i)
      0:       return bcd0;
      1:       return {4'h0, bcd1};
      default: return {4'h0, bcd2};
    endcase
  endfunction

  // Reference: plain decimal arithmetic on the (optionally signed) value.
  task automatic model(input int w, input int d, input int unsigned raw,
                       output logic [11:0] eb, output logic eo, output logic es);
    int unsigned mag, pow, r;
    mag = raw & ((32'd1 << w) - 1);
    es  = 1'b0;
`ifdef DECO_SIGNED_EN
    if (((mag >> (w - 1)) & 1) == 1) begin
      es  = 1'b1;
      mag = (32'd1 << w) - mag;
    end
`endif
    pow = 1;
    for (int k = 0; k < d; k++) pow = pow * 10;
    eo = (mag >= pow);
    r  = mag % pow;
    eb = '0;
    for (int k = 0; k < d; k++) begin
      eb[4*k +: 4] = 4'(r % 10);
      r = r / 10;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic convert(input int i, input int unsigned raw, input int hold, input bit early);
    logic [11:0] eb;
    logic eo, es;
    int n;
    model(w_of(i), d_of(i), raw, eb, eo, es);
    n = 0;
    while (!in_ready[i] && n < 50) begin step(); n++; end
    in_data[i]   = raw[7:0];
    in_valid[i]  = 1'b1;
    out_ready[i] = early;
    step();
    last_accept = cyc;
    in_valid[i] = 1'b0;
    checks++;
    if (in_ready[i] !== 1'b0 || out_valid[i] !== 1'b0) begin
      errors++;
      $display("FAIL accept_drop inst%0d val=%0d: in_ready=%b out_valid=%b, required 0 0",
               i, raw, in_ready[i], out_valid[i]);
    end
    n = 0;
    while (!out_valid[i] && n < 100) begin step(); n++; end
    checks++;
    if (n != w_of(i)) begin
      errors++;
      $display("FAIL latency inst%0d val=%0d: %0d cycles, required %0d", i, raw, n, w_of(i));
    end
    checks++;
    if ({sgn[i], ovf[i], get_bcd(i)} !== {es, eo, eb}) begin
      errors++;
      $display("FAIL result inst%0d val=%0d: sign=%b ovf=%b bcd=%h, required sign=%b ovf=%b bcd=%h",
               i, raw, sgn[i], ovf[i], get_bcd(i), es, eo, eb);
    end
    if (!early) begin
      for (int c = 0; c < hold; c++) begin
        in_valid[i] = 1'b1;
        in_data[i]  = 8'($urandom);
        step();
        checks++;
        if (out_valid[i] !== 1'b1 || in_ready[i] !== 1'b0 ||
            {sgn[i], ovf[i], get_bcd(i)} !== {es, eo, eb}) begin
          errors++;
          $display("FAIL hold inst%0d cyc%0d: out_valid=%b in_ready=%b bcd=%h ovf=%b, required 1 0 %h %b",
                   i, c, out_valid[i], in_ready[i], get_bcd(i), ovf[i], eb, eo);
        end
      end
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b1;
    end
    step();
    out_ready[i] = 1'b0;
    checks++;
    if (out_valid[i] !== 1'b0 || in_ready[i] !== 1'b1) begin
      errors++;
      $display("FAIL handoff inst%0d val=%0d: out_valid=%b in_ready=%b, required 0 1",
               i, raw, out_valid[i], in_ready[i]);
    end
  endtask

  task automatic check_idle(input string name);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready[i] !== 1'b1 || out_valid[i] !== 1'b0 || get_bcd(i) !== 12'h000 ||
          ovf[i] !== 1'b0 || sgn[i] !== 1'b0) begin
        errors++;
        $display("FAIL %s inst%0d: in_ready=%b out_valid=%b bcd=%h ovf=%b sign=%b, required 1 0 000 0 0",
                 name, i, in_ready[i], out_valid[i], get_bcd(i), ovf[i], sgn[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_idle("reset");
  endtask

  task automatic test_basic();
    convert(0, 255, 0, 1'b0);
    convert(0, 0, 0, 1'b0);
    convert(0, 100, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    int prev;
    for (int v = 0; v < 16; v++) begin
      prev = last_accept;
      convert(1, v, 0, 1'b1);
      if (v > 0) begin
        checks++;
        if (last_accept - prev != 6) begin
          errors++;
          $display("FAIL period val=%0d: %0d cycles, required 6", v, last_accept - prev);
        end
      end
    end
  endtask

  task automatic test_overflow();
    convert(2, 150, 0, 1'b0);
    convert(2, 99, 0, 1'b0);
    convert(2, 100, 0, 1'b0);
    convert(0, 999 & 255, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    convert(0, 42, 5, 1'b0);
  endtask

  task automatic test_rst_abort();
    in_data[0]  = 8'd200;
    in_valid[0] = 1'b1;
    step();
    in_valid[0] = 1'b0;
    step();
    step();
    rst = 1'b1;
    in_valid[0] = 1'b1;
    step();
    rst = 1'b0;
    in_valid[0] = 1'b0;
    check_idle("rst_abort");
    convert(0, 7, 0, 1'b0);
  endtask

  task automatic test_signed();
`ifdef DECO_SIGNED_EN
    convert(0, 8'h80, 0, 1'b0);
    convert(0, 8'hFF, 0, 1'b0);
    convert(0, 8'h7F, 0, 1'b0);
`endif
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      int i;
      bit e;
      i = $urandom_range(0, 2);
      e = 1'($urandom);
      convert(i, $urandom_range(0, 255), e ? 0 : $urandom_range(0, 3), e);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = '0;
      out_ready[i] = 1'b0;
    end
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_backpressure();
    test_rst_abort();
    test_signed();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
